// File: rtl/eth_tx_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// eth_tx_arbiter_pkg
// Shared constants, types and helpers for the Ethernet Tx arbiter.
//   - Requester indices (REQ_RESP, REQ_FWD, REQ_STATUS) and vector widths.
//   - Arbiter state encoding (arb_state_e).
//   - Helpers: round-robin index stepping, one-hot to index, saturating
//     timer increment.
// ----------------------------------------------------------------------------
package eth_tx_arbiter_pkg;

    localparam int unsigned NUM_REQ    = 3;
    localparam int unsigned REQ_RESP   = 0;
    localparam int unsigned REQ_FWD    = 1;
    localparam int unsigned REQ_STATUS = 2;

    localparam int unsigned TIMER_W    = 12;
    localparam int unsigned PKT_W      = 8;

    typedef logic [1:0] req_idx_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStart  = 2'd1,
        StActive = 2'd2,
        StGap    = 2'd3
    } arb_state_e;

    // Index visited at step 'offset' of a search that starts just after 'last'.
    function automatic req_idx_t rr_index(input req_idx_t last, input int unsigned offset);
        int unsigned sum;
        sum = 32'(last) + 32'd1 + offset;
        return req_idx_t'(sum % NUM_REQ);
    endfunction

    function automatic req_idx_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        req_idx_t idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = req_idx_t'(i);
            end
        end
        return idx;
    endfunction

    // Timers stick at all-ones rather than wrapping back to zero.
    function automatic logic [TIMER_W-1:0] timer_inc(input logic [TIMER_W-1:0] t);
        return (&t) ? t : t + 1'b1;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// eth_tx_arbiter_if
// Bundles the arbiter request/grant and Tx status signals.
//   master (requesters / MAC side): drives req, resp_priority, tx_active,
//                                   clear_errors; observes the rest.
//   slave  (arbiter):               drives grant, send_start, is_forward,
//                                   start_timeout_err, frame_timeout_err,
//                                   pkt_count.
// ----------------------------------------------------------------------------
interface eth_tx_arbiter_if;
    import eth_tx_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               resp_priority;
    logic               tx_active;
    logic               clear_errors;

    logic [NUM_REQ-1:0] grant;
    logic               send_start;
    logic               is_forward;
    logic               start_timeout_err;
    logic               frame_timeout_err;
    logic [PKT_W-1:0]   pkt_count;

    modport master (
        output req,
        output resp_priority,
        output tx_active,
        output clear_errors,
        input  grant,
        input  send_start,
        input  is_forward,
        input  start_timeout_err,
        input  frame_timeout_err,
        input  pkt_count
    );

    modport slave (
        input  req,
        input  resp_priority,
        input  tx_active,
        input  clear_errors,
        output grant,
        output send_start,
        output is_forward,
        output start_timeout_err,
        output frame_timeout_err,
        output pkt_count
    );

endinterface

// File: rtl/eth_rr_picker.sv
// ----------------------------------------------------------------------------
// eth_rr_picker
// Combinational winner selection for the Tx arbiter.
//   i_req           : level requests, one bit per requester
//   i_last_grant    : index of the most recent grant (round-robin pointer)
//   i_resp_priority : when set, a pending response request always wins
//   o_grant         : one-hot winner, zero when nothing is requested
// ----------------------------------------------------------------------------
module eth_rr_picker
    import eth_tx_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  req_idx_t           i_last_grant,
    input  logic               i_resp_priority,
    output logic [NUM_REQ-1:0] o_grant
);

    req_idx_t w_idx;
    logic     w_found;

    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        if (i_resp_priority && i_req[REQ_RESP]) begin
            o_grant[REQ_RESP] = 1'b1;
        end else begin
            // First requester found walking upward from last_grant+1, with wrap.
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                w_idx = rr_index(i_last_grant, k);
                if (!w_found && i_req[w_idx]) begin
                    o_grant[w_idx] = 1'b1;
                    w_found        = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// ----------------------------------------------------------------------------
// eth_tx_arbiter
// Grants one of three Tx requesters access to the real-time Ethernet
// transmitter, supervises the frame via tx_active and enforces an
// inter-packet gap before the next grant.
//   clk      : single clock
//   reset    : asynchronous, active-high
//   arb_if   : slave modport of eth_tx_arbiter_if
//              in : req[2:0], resp_priority, tx_active, clear_errors
//              out: grant[2:0] (one-hot, held for the frame), send_start
//                   (pulse on first grant cycle), is_forward, sticky
//                   start_timeout_err / frame_timeout_err, pkt_count[7:0]
// Parameters:
//   IPG_CYCLES    : idle clocks (grant=0) spent in GAP after each frame
//   START_TIMEOUT : clocks allowed from grant to tx_active rising
//   FRAME_TIMEOUT : clocks tx_active may stay high per frame
// ----------------------------------------------------------------------------
module eth_tx_arbiter
    import eth_tx_arbiter_pkg::*;
#(
    parameter int unsigned IPG_CYCLES    = 12,
    parameter int unsigned START_TIMEOUT = 64,
    parameter int unsigned FRAME_TIMEOUT = 2048
) (
    input  logic            clk,
    input  logic            reset,
    eth_tx_arbiter_if.slave arb_if
);

    localparam logic [TIMER_W-1:0] START_LIMIT = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] FRAME_LIMIT = TIMER_W'(FRAME_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD    = TIMER_W'(IPG_CYCLES - 1);

    arb_state_e         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_send_start;
    logic               r_is_forward;
    logic               r_start_err;
    logic               r_frame_err;
    logic [PKT_W-1:0]   r_pkt_count;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] r_gap_cnt;
    req_idx_t           r_last_grant;

    logic [NUM_REQ-1:0] w_pick;

    eth_rr_picker u_picker (
        .i_req           (arb_if.req),
        .i_last_grant    (r_last_grant),
        .i_resp_priority (arb_if.resp_priority),
        .o_grant         (w_pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_grant      <= '0;
            r_send_start <= 1'b0;
            r_is_forward <= 1'b0;
            r_start_err  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_pkt_count  <= '0;
            r_timer      <= '0;
            r_gap_cnt    <= '0;
            // Pointer at the last index so the first search begins at index 0.
            r_last_grant <= req_idx_t'(REQ_STATUS);
        end else begin
            r_send_start <= 1'b0;

            // Clears are scheduled first so an error set below in the same
            // cycle overrides them.
            if (arb_if.clear_errors) begin
                r_start_err <= 1'b0;
                r_frame_err <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    if (|arb_if.req) begin
                        r_grant      <= w_pick;
                        r_is_forward <= w_pick[REQ_FWD];
                        r_send_start <= 1'b1;
                        r_timer      <= '0;
                        r_last_grant <= onehot_to_idx(w_pick);
                        r_state      <= StStart;
                    end
                end

                StStart: begin
                    if (arb_if.tx_active) begin
                        r_timer <= '0;
                        r_state <= StActive;
                    end else if (r_timer == START_LIMIT) begin
                        r_start_err  <= 1'b1;
                        r_grant      <= '0;
                        r_is_forward <= 1'b0;
                        r_gap_cnt    <= GAP_LOAD;
                        r_state      <= StGap;
                    end else begin
                        r_timer <= timer_inc(r_timer);
                    end
                end

                StActive: begin
                    // A normal end of frame takes precedence over the timeout.
                    if (!arb_if.tx_active) begin
                        r_pkt_count  <= r_pkt_count + 1'b1;
                        r_grant      <= '0;
                        r_is_forward <= 1'b0;
                        r_gap_cnt    <= GAP_LOAD;
                        r_state      <= StGap;
                    end else if (r_timer == FRAME_LIMIT) begin
                        r_frame_err  <= 1'b1;
                        r_grant      <= '0;
                        r_is_forward <= 1'b0;
                        r_gap_cnt    <= GAP_LOAD;
                        r_state      <= StGap;
                    end else begin
                        r_timer <= timer_inc(r_timer);
                    end
                end

                StGap: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= StIdle;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end

                default: begin
                    r_grant      <= '0;
                    r_is_forward <= 1'b0;
                    r_state      <= StIdle;
                end
            endcase
        end
    end

    assign arb_if.grant             = r_grant;
    assign arb_if.send_start        = r_send_start;
    assign arb_if.is_forward        = r_is_forward;
    assign arb_if.start_timeout_err = r_start_err;
    assign arb_if.frame_timeout_err = r_frame_err;
    assign arb_if.pkt_count         = r_pkt_count;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
module tb_eth_tx_arbiter;
    import eth_tx_arbiter_pkg::*;

    localparam int unsigned IPG   = 12;
    localparam int unsigned ST_TO = 64;
    localparam int unsigned FR_TO = 2048;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    eth_tx_arbiter_if bus ();

    eth_tx_arbiter #(
        .IPG_CYCLES    (IPG),
        .START_TIMEOUT (ST_TO),
        .FRAME_TIMEOUT (FR_TO)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .arb_if (bus)
    );

    typedef struct {
        logic [2:0] grant;
        logic [7:0] pkts;
        bit         exact_gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   model_last = 2;
    int   model_pkts = 0;
    logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference arbitration: priority response, else first requester after the
    // previously granted index, wrapping around the three requesters.
    function automatic int pick(input logic [2:0] r, input bit prio);
        if (prio && r[0]) return 0;
        for (int i = 1; i <= 3; i++) begin
            if (r[(model_last + i) % 3]) return (model_last + i) % 3;
        end
        return -1;
    endfunction

    task automatic issue(input logic [2:0] r, input bit prio, input bit exact);
        int   w;
        exp_t e;
        w           = pick(r, prio);
        e.grant     = 3'(1 << w);
        e.pkts      = 8'(model_pkts % 256);
        e.exact_gap = exact;
        exp_q.push_back(e);
        model_last        = w;
        bus.req           = r;
        bus.resp_priority = prio;
    endtask

    task automatic wait_grant(output bit ok, output logic [2:0] g);
        ok = 1'b0;
        g  = 3'b000;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.send_start === 1'b1) begin
                ok = 1'b1;
                g  = bus.grant;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_wait: actual no send_start in 200 cycles, required a grant");
        end
        bus.req = 3'b000;
    endtask

    task automatic run_frame(input int dly, input int len, input bit junk,
                             output logic [2:0] g);
        bit ok;
        wait_grant(ok, g);
        if (ok) begin
            repeat (dly) begin
                @(negedge clk);
                if (junk) bus.req = 3'($urandom);
            end
            bus.tx_active = 1'b1;
            repeat (len) begin
                @(negedge clk);
                if (junk) bus.req = 3'($urandom);
            end
            bus.tx_active = 1'b0;
            bus.req       = 3'b000;
            model_pkts++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},      32'(bus.grant), 32'd0);
        check({tag, "_send_start"}, 32'(bus.send_start), 32'd0);
        check({tag, "_is_forward"}, 32'(bus.is_forward), 32'd0);
        check({tag, "_start_err"},  32'(bus.start_timeout_err), 32'd0);
        check({tag, "_frame_err"},  32'(bus.frame_timeout_err), 32'd0);
        check({tag, "_pkt_count"},  32'(bus.pkt_count), 32'd0);
    endtask

    // Monitor: pops the scoreboard on each send_start and checks the grant.
    initial begin : monitor
        int   zero_run;
        bit   first;
        logic prev_ss;
        exp_t e;
        zero_run = 0;
        first    = 1'b1;
        prev_ss  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                first    = 1'b1;
                zero_run = 0;
                prev_ss  = 1'b0;
            end else begin
                if (bus.send_start === 1'b1) begin
                    check("send_start_pulse", 32'(prev_ss), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_grant: actual grant %b, required none", bus.grant);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant", 32'(bus.grant), 32'(e.grant));
                        check("is_forward", 32'(bus.is_forward), 32'(e.grant[1]));
                        check("pkt_count_at_grant", 32'(bus.pkt_count), 32'(e.pkts));
                        if (!first && e.exact_gap) check("ipg_gap", 32'(zero_run), IPG + 1);
                    end
                    zero_run = 0;
                    first    = 1'b0;
                end else if (bus.grant === 3'b000) begin
                    zero_run++;
                end else begin
                    zero_run = 0;
                end
                prev_ss = bus.send_start;
            end
        end
    end

    initial begin : watchdog
        #(1_000_000);
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit         ok;
        logic [2:0] g;

        reset             = 1'b1;
        bus.req           = 3'b000;
        bus.resp_priority = 1'b0;
        bus.tx_active     = 1'b0;
        bus.clear_errors  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Pure round-robin with all requesters active.
        for (int i = 0; i < 4; i++) begin
            issue(3'b111, 1'b0, i > 0);
            run_frame(0, 70, 1'b0, g);
            check("rr_order", 32'(g), 32'(rr_exp[i]));
        end

        // Response priority, then fall back to the pointer.
        for (int i = 0; i < 3; i++) begin
            issue(3'b111, 1'b1, 1'b1);
            run_frame(0, 5, 1'b0, g);
            check("prio_grant", 32'(g), 32'd1);
        end
        issue(3'b110, 1'b1, 1'b1);
        run_frame(1, 5, 1'b0, g);
        check("prio_drop_follows_ptr", 32'(g), 32'(3'b010));

        // Single forward frame with tx_active starting 3 clocks after grant.
        issue(3'b010, 1'b0, 1'b1);
        wait_grant(ok, g);
        check("fwd_grant", 32'(g), 32'(3'b010));
        repeat (3) @(negedge clk);
        bus.tx_active = 1'b1;
        check("fwd_is_forward", 32'(bus.is_forward), 32'd1);
        check("fwd_single_start", 32'(bus.send_start), 32'd0);
        repeat (80) @(negedge clk);
        bus.tx_active = 1'b0;
        model_pkts++;
        issue(3'b100, 1'b0, 1'b1);
        @(negedge clk);
        check("fwd_pkt_count", 32'(bus.pkt_count), 32'(model_pkts % 256));
        check("fwd_grant_drop", 32'(bus.grant), 32'd0);
        run_frame(2, 10, 1'b1, g);

        // Randomised traffic.
        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), 1'b1);
            run_frame(int'($urandom_range(0, 6)), int'($urandom_range(1, 40)), 1'b1, g);
        end

        // Start timeout: tx_active never rises.
        issue(3'b001, 1'b0, 1'b1);
        wait_grant(ok, g);
        repeat (ST_TO - 1) @(negedge clk);
        check("st_err_before", 32'(bus.start_timeout_err), 32'd0);
        check("st_grant_before", 32'(bus.grant), 32'd1);
        @(negedge clk);
        check("st_err_set", 32'(bus.start_timeout_err), 32'd1);
        check("st_grant_cleared", 32'(bus.grant), 32'd0);
        check("st_pkt_unchanged", 32'(bus.pkt_count), 32'(model_pkts % 256));
        @(negedge clk);
        bus.clear_errors = 1'b1;
        @(negedge clk);
        bus.clear_errors = 1'b0;
        check("st_err_cleared", 32'(bus.start_timeout_err), 32'd0);

        // Frame timeout with clear_errors coincident with the set.
        issue(3'b100, 1'b0, 1'b0);
        wait_grant(ok, g);
        bus.tx_active = 1'b1;
        repeat (FR_TO) @(negedge clk);
        check("ft_err_before", 32'(bus.frame_timeout_err), 32'd0);
        check("ft_grant_before", 32'(bus.grant), 32'(3'b100));
        bus.clear_errors = 1'b1;
        @(negedge clk);
        bus.clear_errors = 1'b0;
        check("ft_err_set_wins", 32'(bus.frame_timeout_err), 32'd1);
        check("ft_grant_cleared", 32'(bus.grant), 32'd0);
        repeat (3000 - FR_TO - 1) @(negedge clk);
        bus.tx_active = 1'b0;
        @(negedge clk);
        check("ft_pkt_unchanged", 32'(bus.pkt_count), 32'(model_pkts % 256));
        check("ft_err_sticky", 32'(bus.frame_timeout_err), 32'd1);

        // Asynchronous reset in the middle of an active frame.
        issue(3'b010, 1'b0, 1'b0);
        wait_grant(ok, g);
        bus.tx_active = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        model_pkts    = 0;
        model_last    = 2;
        bus.tx_active = 1'b0;
        bus.req       = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 256 short frames: pkt_count wraps back to zero.
        for (int i = 0; i < 256; i++) begin
            issue(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), i > 0);
            run_frame(0, 1, 1'b0, g);
        end
        @(negedge clk);
        check("pkt_wrap", 32'(bus.pkt_count), 32'd0);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter IPG_CYCLES, default 12, minimum idle clocks between end of one Tx frame and next grant.
REQ-002 Parameter START_TIMEOUT, default 64, max clocks from grant to tx_active rising.
REQ-003 Parameter FRAME_TIMEOUT, default 2048, max clocks tx_active may stay high per frame.
REQ-004 clk  input  1  single clock for all logic; one clock; reset is asynchronous and active-high.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  3  level requests; bit0 = response, bit1 = FireWire forward, bit2 = status/broadcast.
REQ-007 resp_priority  input  1  1 -> req[0] always wins when set; 0 -> pure round-robin.
REQ-008 tx_active  input  1  Tx enable from real-time Ethernet interface (high while preamble/data/CRC driven).
REQ-009 clear_errors  input  1  clears sticky error flags.
REQ-010 grant  output  3  one-hot grant, held from grant cycle until frame ends or times out.
REQ-011 send_start  output  1  single-cycle pulse coincident with first cycle grant is high.
REQ-012 is_forward  output  1  registered copy of grant[1].
REQ-013 start_timeout_err  output  1  sticky, grant not followed by tx_active.
REQ-014 frame_timeout_err  output  1  sticky, tx_active exceeded FRAME_TIMEOUT.
REQ-015 pkt_count  output  8  count of completed frames, wraps 255 -> 0.

Function
REQ-016 States SHALL be IDLE, START, ACTIVE, GAP; any other encoding SHALL return to IDLE next clock.
REQ-017 IDLE: req sampled only here; if req != 0, winner's grant bit and send_start SHALL be set on next clock edge, timer cleared, state -> START.
REQ-018 Round-robin SHALL search from index (last_grant+1) mod 3 upward with wrap; last_grant updates on every grant, including priority grants.
REQ-019 With resp_priority=1 and req[0]=1, grant SHALL be 3'b001 regardless of pointer.
REQ-020 START: tx_active=1 -> ACTIVE, timer cleared; timer reaching START_TIMEOUT-1 with tx_active=0 -> start_timeout_err set, grant cleared, -> GAP.
REQ-021 ACTIVE: tx_active falling (sampled 0) -> grant cleared, pkt_count+1, -> GAP; timer reaching FRAME_TIMEOUT-1 -> frame_timeout_err set, grant cleared, -> GAP (no pkt_count increment).
REQ-022 GAP: gap counter loaded with IPG_CYCLES-1 on entry, decremented each clock; at 0 -> IDLE; total gap = IPG_CYCLES clocks with grant=0.
REQ-023 Requests dropped or raised outside IDLE SHALL have no effect until next IDLE.
REQ-024 Grant-to-next-grant minimum latency SHALL be 1 (START) + frame cycles + IPG_CYCLES + 1 (IDLE).
REQ-025 clear_errors coincident with an error-setting event: set SHALL win.
REQ-026 Timers SHALL be 12 bits wide, saturating, never wrapping.

Reset
REQ-027 reset SHALL asynchronously force state IDLE, grant 0, send_start 0, is_forward 0, both error flags 0, pkt_count 0, timers 0, last_grant 2 (first round-robin search starts at index 0).
REQ-028 reset asserted mid-frame SHALL drop grant immediately; no pkt_count update.

Structure
REQ-029 State encodings and requester indices (REQ_RESP=0, REQ_FWD=1, REQ_STATUS=2) SHALL live in the shared constants include.
REQ-030 Winner selection SHALL be one combinational sub-module, eth_rr_picker (inputs req, last_grant, resp_priority; output one-hot).

Verification
REQ-031 Reset release, req=3'b010, tx_active high 3 clocks after grant for 80 clocks -> grant=010 and send_start one pulse, is_forward=1, pkt_count=1, grant 0 for 12 clocks then IDLE.
REQ-032 req=3'b111 held, resp_priority=0, each frame 70 clocks -> grants 001, 010, 100, 001 in order.
REQ-033 req=3'b111 held, resp_priority=1 -> every grant 001; drop req[0] -> next grant follows pointer (010).
REQ-034 Grant with tx_active held 0 -> start_timeout_err=1 after 64 clocks, grant 0, GAP entered; clear_errors pulse -> flag 0.
REQ-035 tx_active held high 3000 clocks -> frame_timeout_err=1 at 2048, pkt_count unchanged; clear_errors same cycle as set -> flag stays 1.
REQ-036 reset asserted in ACTIVE -> grant 0 same cycle (asynchronous), all outputs at reset values; 256 frames -> pkt_count wraps to 0.
